uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Buffers bytes written by the core to the UART TX memory-mapped register in a small FIFO.
- Sequences those bytes one at a time into the UART transmitter using its start_TX / tx_active handshake.
- Sits between the memory-mapped register decode (which produces the write strobe) and the UART TX core.
- Lets the core issue back-to-back writes without polling tx_active per byte.

Parameters:
- FIFO_DEPTH_LOG2, 4, log2 of FIFO entries (depth = 16).
- ACTIVE_TIMEOUT, 8, max cycles to wait for tx_active to rise after start_TX before the byte is treated as sent.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- sync_reset  input  1  synchronous clear, active-high.
- wr_enable  input  1  one-cycle strobe: core write to the UART TX address.
- wr_data  input  8  byte to queue.
- clear_overflow  input  1  clears the sticky overflow flag.
- tx_active  input  1  UART transmitter busy.
- start_TX  output  1  one-cycle launch pulse to the UART.
- tx_data  output  8  byte presented to the UART; stable from start_TX until the next launch.
- fifo_count  output  FIFO_DEPTH_LOG2+1  entries queued.
- fifo_full  output  1  fifo_count == depth.
- tx_busy  output  1  FIFO non-empty, or FSM not in IDLE, or tx_active.
- overflow  output  1  sticky: a write was dropped.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values (reset, or sync_reset at a clock edge): start_TX=0, tx_data=0, fifo_count=0, fifo_full=0, overflow=0, FSM=IDLE, read/write pointers=0.
- FIFO is circular; pointers are FIFO_DEPTH_LOG2 bits and wrap modulo depth.
- Push: when wr_enable=1 and fifo_count<depth (count before this edge), store wr_data at wr_ptr and increment wr_ptr.
- Push while full: byte is dropped, overflow<=1, pointers unchanged. This holds even if a pop happens in the same cycle.
- Simultaneous push and pop with count in 1..depth-1: count unchanged, both pointers advance.
- overflow clears on clear_overflow=1. If clear_overflow and a dropped write occur in the same cycle, the set wins.
- FSM states:
  - IDLE: if fifo_count>0 and tx_active=0, then tx_data<=head, pop, go to LAUNCH.
  - LAUNCH: start_TX=1 for exactly this cycle; timer<=0; go to WAIT_ACTIVE.
  - WAIT_ACTIVE: if tx_active=1, go to WAIT_DONE. Otherwise timer++; when timer==ACTIVE_TIMEOUT-1, go to IDLE (byte treated as sent).
  - WAIT_DONE: when tx_active=0, go to IDLE.
- start_TX is registered and decoded from state==LAUNCH; it is never high two cycles in a row.
- Latency: write at edge N into an empty FIFO with FSM in IDLE and tx_active=0 gives count=1 after N, pop at N+1, and start_TX high in the cycle after edge N+1.
- Byte-to-byte spacing is at least the UART busy time + 2 cycles (IDLE→LAUNCH overhead).
- Empty FIFO: FSM stays in IDLE; start_TX stays 0.
- Reset mid-operation: the UART may still be active. IDLE refuses to launch until tx_active=0, so no byte is corrupted by a launch during an in-flight frame.
- fifo_full and fifo_count are registered and update on the edge after the push or pop.

Optional Feature:
- Macro: UART_TX_CRLF_EN.
- Defined: when the popped byte is 0x0A, the FSM first launches 0x0D, then launches 0x0A without popping again. This uses an extra flag, pending_lf. tx_busy includes pending_lf. sync_reset/reset clear pending_lf.
- Undefined: bytes are transmitted verbatim; no pending_lf logic is synthesized.

Test Plan:
- Single byte: write 0x41 with tx_active low; UART model holds tx_active high 10 cycles after start_TX → start_TX pulses once 2 cycles after the write, tx_data=0x41, tx_busy falls 1 cycle after tx_active falls.
- Burst: 16 back-to-back writes 0x00..0x0F → fifo_full=1 after the 16th write, no overflow; bytes launched in order 0x00..0x0F, one start_TX per byte.
- Overflow: 17 writes while tx_active is held high → 17th byte dropped, overflow=1, count=16. Then pulse clear_overflow → overflow=0; 16 bytes emitted.
- Timeout: tx_active never rises → after start_TX, FSM returns to IDLE after 8 cycles and launches the next byte; no deadlock.
- Reset mid-frame: assert reset while tx_active=1 with 3 bytes queued → count=0, start_TX=0. After release with a new write, start_TX waits until tx_active falls.
- With UART_TX_CRLF_EN: write 0x0A → two launches, tx_data 0x0D then 0x0A. Without it → a single launch of 0x0A.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: buffers core writes in a circular FIFO and launches them one at a time into the UART TX.
// Optional UART_TX_CRLF_EN: each LF (0x0A) is sent as CR (0x0D) followed by LF.
module uart_tx_scheduler #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int ACTIVE_TIMEOUT  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sync_reset,
    input  logic                     wr_enable,
    input  logic [7:0]               wr_data,
    input  logic                     clear_overflow,
    input  logic                     tx_active,
    output logic                     start_TX,
    output logic [7:0]               tx_data,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     fifo_full,
    output logic                     tx_busy,
    output logic                     overflow,
    output logic [1:0]               state_dbg
);

    // Handshake: start_TX is a one-cycle launch with tx_data held until the next launch; the UART
    // acknowledges by raising tx_active and the frame ends when tx_active falls. A missing acknowledge
    // is forgiven after ACTIVE_TIMEOUT cycles so the queue never deadlocks.
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam int TW = (ACTIVE_TIMEOUT > 1) ? $clog2(ACTIVE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACTIVE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LAUNCH      = 2'd1,
        WAIT_ACTIVE = 2'd2,
        WAIT_DONE   = 2'd3
    } state_t;

    state_t                     state, state_next;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0]              timer, timer_next;
    logic [7:0]                 tx_data_next;
    logic [FIFO_DEPTH_LOG2:0]   count_next;
    logic                       push, drop, pop;
`ifdef UART_TX_CRLF_EN
    logic                       pending_lf, pending_lf_next;
`endif

    // A write into a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign push = wr_enable && !fifo_full;
    assign drop = wr_enable && fifo_full;

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        tx_data_next = tx_data;
        pop          = 1'b0;
`ifdef UART_TX_CRLF_EN
        pending_lf_next = pending_lf;
`endif
        case (state)
            IDLE: begin
                if (!tx_active) begin
`ifdef UART_TX_CRLF_EN
                    if (pending_lf) begin
                        tx_data_next    = 8'h0A;
                        pending_lf_next = 1'b0;
                        state_next      = LAUNCH;
                    end else if (fifo_count != '0) begin
                        pop        = 1'b1;
                        state_next = LAUNCH;
                        if (mem[rd_ptr] == 8'h0A) begin
                            tx_data_next    = 8'h0D;
                            pending_lf_next = 1'b1;
                        end else begin
                            tx_data_next = mem[rd_ptr];
                        end
                    end
`else
                    if (fifo_count != '0) begin
                        pop          = 1'b1;
                        tx_data_next = mem[rd_ptr];
                        state_next   = LAUNCH;
                    end
`endif
                end
            end
            LAUNCH: begin
                timer_next = '0;
                state_next = WAIT_ACTIVE;
            end
            WAIT_ACTIVE: begin
                if (tx_active) begin
                    state_next = WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_active) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            start_TX <= 1'b0;
        end else if (sync_reset) begin
            state    <= IDLE;
            timer    <= '0;
            start_TX <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            start_TX <= (state_next == LAUNCH);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data    <= 8'h00;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
        end else if (sync_reset) begin
            tx_data    <= 8'h00;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
        end else begin
            tx_data    <= tx_data_next;
            fifo_count <= count_next;
            fifo_full  <= (count_next == DEPTH_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_TX_CRLF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_lf <= 1'b0;
        end else if (sync_reset) begin
            pending_lf <= 1'b0;
        end else begin
            pending_lf <= pending_lf_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef UART_TX_CRLF_EN
    assign tx_busy = (fifo_count != '0) || (state != IDLE) || tx_active || pending_lf;
`else
    assign tx_busy = (fifo_count != '0) || (state != IDLE) || tx_active;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: queue-level reference model checked every cycle, UART responder model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_scheduler;

    localparam int FIFO_DEPTH_LOG2 = 4;
    localparam int DEPTH           = 16;
    localparam int ACTIVE_TIMEOUT  = 8;

    logic       clk = 1'b0;
    logic       reset, sync_reset, wr_enable, clear_overflow, tx_active;
    logic [7:0] wr_data;
    logic       start_TX, fifo_full, tx_busy, overflow;
    logic [7:0] tx_data;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic [1:0] state_dbg;

    uart_tx_scheduler #(
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2),
        .ACTIVE_TIMEOUT (ACTIVE_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sync_reset    (sync_reset),
        .wr_enable     (wr_enable),
        .wr_data       (wr_data),
        .clear_overflow(clear_overflow),
        .tx_active     (tx_active),
        .start_TX      (start_TX),
        .tx_data       (tx_data),
        .fifo_count    (fifo_count),
        .fifo_full     (fifo_full),
        .tx_busy       (tx_busy),
        .overflow      (overflow),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queued bytes plus where the current byte is in its life
    // (just launched / awaiting acknowledge for m_window more edges / in frame).
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] launched[$];
    bit         m_ovf, m_launch, m_frame, m_lf;
    int         m_window;
    logic [7:0] m_txd;

    // UART responder: 0 = normal, 1 = never acknowledges, 2 = tx_active driven by the test.
    int u_mode = 0;
    int u_rise = -1;
    int u_hold = 0;
    int u_dmin = 0, u_dmax = 0, u_lmin = 3, u_lmax = 3;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        exp_q.delete();
        m_ovf    = 1'b0;
        m_launch = 1'b0;
        m_frame  = 1'b0;
        m_lf     = 1'b0;
        m_window = 0;
        m_txd    = 8'h00;
    endtask

    task automatic model_step();
        int old_len;
        bit free, act;
        act = (tx_active === 1'b1);
        if (sync_reset) begin
            model_clear();
            return;
        end
        old_len = m_q.size();
        free    = !m_launch && (m_window == 0) && !m_frame;
        if (m_launch) begin
            m_launch = 1'b0;
            m_window = ACTIVE_TIMEOUT;
        end else if (m_window > 0) begin
            if (act) begin
                m_window = 0;
                m_frame  = 1'b1;
            end else begin
                m_window--;
            end
        end else if (m_frame && !act) begin
            m_frame = 1'b0;
        end
        if (free && !act) begin
            if (m_lf) begin
                m_lf     = 1'b0;
                m_txd    = 8'h0A;
                m_launch = 1'b1;
            end else if (old_len > 0) begin
                m_txd    = m_q.pop_front();
                m_launch = 1'b1;
`ifdef UART_TX_CRLF_EN
                if (m_txd == 8'h0A) begin
                    m_txd = 8'h0D;
                    m_lf  = 1'b1;
                end
`endif
            end
        end
        if (clear_overflow) m_ovf = 1'b0;
        if (wr_enable) begin
            if (old_len == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                m_q.push_back(wr_data);
`ifdef UART_TX_CRLF_EN
                if (wr_data == 8'h0A) exp_q.push_back(8'h0D);
`endif
                exp_q.push_back(wr_data);
            end
        end
    endtask

    task automatic check_outputs();
        bit busy_exp;
        busy_exp = (m_q.size() > 0) || m_launch || (m_window > 0) || m_frame || m_lf ||
                   (tx_active === 1'b1);
        chk("start_TX", 32'(start_TX), 32'(m_launch));
        chk("tx_data", 32'(tx_data), 32'(m_txd));
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("tx_busy", 32'(tx_busy), 32'(busy_exp));
        if (start_TX === 1'b1) begin
            launched.push_back(tx_data);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL launch_order: got 0x%0h want no launch", tx_data);
            end else begin
                chk("launch_order", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic uart_update();
        if (u_mode == 1) begin
            tx_active = 1'b0;
        end else if (u_mode == 0) begin
            if (start_TX === 1'b1 && u_hold == 0 && u_rise < 0) u_rise = $urandom_range(u_dmax, u_dmin);
            if (u_rise == 0) begin
                u_rise = -1;
                u_hold = $urandom_range(u_lmax, u_lmin);
            end else if (u_rise > 0) begin
                u_rise--;
            end
            if (u_hold > 0) begin
                tx_active = 1'b1;
                u_hold--;
            end else begin
                tx_active = 1'b0;
            end
        end
    endtask

    // One clock: respond as the UART, predict the edge, then compare just after the next negedge.
    task automatic tick();
        uart_update();
        model_step();
        @(posedge clk);
        @(negedge clk);
        wr_enable      = 1'b0;
        clear_overflow = 1'b0;
        sync_reset     = 1'b0;
        check_outputs();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_enable = 1'b1;
        wr_data   = b;
        tick();
    endtask

    task automatic wait_drain(input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            if (tx_busy === 1'b0 && exp_q.size() == 0) done = 1'b1;
            else tick();
        end
        if (!done && tx_busy === 1'b0 && exp_q.size() == 0) done = 1'b1;
        chk("drain_idle", 32'(done), 32'd1);
    endtask

    task automatic wait_launch(input int bound, output int gap);
        gap = 0;
        while (start_TX !== 1'b1 && gap < bound) begin
            tick();
            gap++;
        end
    endtask

    function automatic logic [7:0] launched_at(input int i);
        if (i < launched.size()) return launched[i];
        return 8'hxx;
    endfunction

    initial begin
        int gap;
        reset          = 1'b1;
        sync_reset     = 1'b0;
        wr_enable      = 1'b0;
        wr_data        = 8'h00;
        clear_overflow = 1'b0;
        tx_active      = 1'b0;
        model_clear();

        // Reset state
        @(negedge clk);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_start", 32'(start_TX), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        reset = 1'b0;
        tick();

        // Single byte with a 10-cycle UART frame
        u_mode = 0; u_dmin = 0; u_dmax = 0; u_lmin = 10; u_lmax = 10;
        write_byte(8'h41);
        chk("single_count", 32'(fifo_count), 32'd1);
        chk("single_no_start", 32'(start_TX), 32'd0);
        tick();
        chk("single_start", 32'(start_TX), 32'd1);
        chk("single_data", 32'(tx_data), 32'h41);
        for (int i = 0; i < 10; i++) tick();
        chk("single_busy_hold", 32'(tx_busy), 32'd1);
        tick();
        chk("single_busy_fall", 32'(tx_busy), 32'd0);
        chk("single_no_restart", 32'(start_TX), 32'd0);

        // Burst of 16 while the UART is busy, then drain in order
        u_mode = 2; tx_active = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        chk("burst_full", 32'(fifo_full), 32'd1);
        chk("burst_count", 32'(fifo_count), 32'd16);
        chk("burst_no_ovf", 32'(overflow), 32'd0);
        launched.delete();
        u_mode = 0; u_lmin = 3; u_lmax = 3;
        wait_drain(600);
        chk("burst_launches", 32'(launched.size()), 32'd16);
        chk("burst_first", 32'(launched_at(0)), 32'h00);
        chk("burst_last", 32'(launched_at(15)), 32'h0F);

        // Overflow, set-wins-over-clear, clear, and drop while popping
        u_mode = 2; tx_active = 1'b1;
        for (int i = 0; i < 17; i++) write_byte(8'(8'h80 + i));
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(fifo_count), 32'd16);
        clear_overflow = 1'b1;
        write_byte(8'hEF);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        chk("ovf_cleared", 32'(overflow), 32'd0);
        launched.delete();
        tx_active = 1'b0;
        write_byte(8'hEE);
        chk("ovf_pop_drop", 32'(overflow), 32'd1);
        chk("ovf_pop_count", 32'(fifo_count), 32'd15);
        chk("ovf_pop_start", 32'(start_TX), 32'd1);
        u_mode = 0;
        wait_drain(600);
        chk("ovf_launches", 32'(launched.size()), 32'd16);

        // Acknowledge timeout: UART never raises tx_active
        u_mode = 1;
        clear_overflow = 1'b1;
        write_byte(8'hA1);
        write_byte(8'hA2);
        wait_launch(30, gap);
        chk("to_first_data", 32'(tx_data), 32'hA1);
        tick();
        wait_launch(30, gap);
        chk("to_gap", 32'(gap + 1), 32'd10);
        chk("to_second_data", 32'(tx_data), 32'hA2);
        wait_drain(100);

        // Async reset with a frame in flight and bytes queued
        u_mode = 2; tx_active = 1'b1;
        write_byte(8'hC1);
        write_byte(8'hC2);
        write_byte(8'hC3);
        reset = 1'b1;
        #1;
        chk("rmid_count", 32'(fifo_count), 32'd0);
        chk("rmid_start", 32'(start_TX), 32'd0);
        chk("rmid_full", 32'(fifo_full), 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
        write_byte(8'hD5);
        for (int i = 0; i < 5; i++) begin
            chk("rmid_hold_start", 32'(start_TX), 32'd0);
            tick();
        end
        chk("rmid_queued", 32'(fifo_count), 32'd1);
        tx_active = 1'b0;
        tick();
        chk("rmid_launch", 32'(start_TX), 32'd1);
        chk("rmid_launch_data", 32'(tx_data), 32'hD5);
        u_mode = 0;
        wait_drain(100);

        // Line feed handling
        u_mode = 0; u_lmin = 2; u_lmax = 2;
        launched.delete();
        write_byte(8'h0A);
        wait_drain(100);
`ifdef UART_TX_CRLF_EN
        chk("lf_launches", 32'(launched.size()), 32'd2);
        chk("lf_cr_first", 32'(launched_at(0)), 32'h0D);
        chk("lf_lf_second", 32'(launched_at(1)), 32'h0A);
`else
        chk("lf_launches", 32'(launched.size()), 32'd1);
        chk("lf_verbatim", 32'(launched_at(0)), 32'h0A);
`endif

        // Randomized traffic with late/absent acknowledges and occasional clears
        u_mode = 0; u_dmin = 0; u_dmax = 10; u_lmin = 1; u_lmax = 6;
        for (int i = 0; i < 2000; i++) begin
            int pct;
            pct = (((i / 200) % 2) == 0) ? 75 : 15;
            wr_enable      = ($urandom_range(99, 0) < pct);
            wr_data        = ($urandom_range(7, 0) == 0) ? 8'h0A : 8'($urandom_range(255, 0));
            clear_overflow = ($urandom_range(99, 0) < 3);
            sync_reset     = ($urandom_range(199, 0) == 0);
            tick();
        end
        wait_drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
